// File: rtl/seg_capture_pkg.sv
// Shared constants for the seven-segment display capture block.
package seg_capture_pkg;

   localparam int PAT_W  = 7;
   localparam int DIGITS = 4;
   localparam int NIB_W  = 4;

   // Active-low {g,f,e,d,c,b,a} glyphs, indexed by the hex value they show.
   localparam logic [PAT_W-1:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic [NIB_W-1:0] nib;
      logic             dp;
      logic             err;
   } slot_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns flag err.
module seg7_decode
   import seg_capture_pkg::*;
(
   input  logic [PAT_W-1:0] i_seg,
   output logic [NIB_W-1:0] o_nibble,
   output logic             o_err
);

   // Search the glyph table; no match leaves nibble 0 with the error bit set.
   always_comb begin
      o_nibble = '0;
      o_err    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i_seg == GLYPH[i]) begin
            o_nibble = NIB_W'(i);
            o_err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_display_capture.sv
// Captures a multiplexed 4-digit seven-segment display into a 16-bit value.
module seg_display_capture
   import seg_capture_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an_in,
   input  logic [7:0]  seg_in,
   output logic [15:0] value,
   output logic [3:0]  dp_out,
   output logic        value_valid,
   output logic        frame_err,
   output logic        timeout
);

   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [3:0]        r_an_s1, r_an_s2;
   logic [7:0]        r_seg_s1, r_seg_s2;
   logic [11:0]       r_prev;
   logic [STAB_W-1:0] r_stab;
   logic [TO_W-1:0]   r_to;
   logic [3:0]        r_seen;
   slot_t             r_slot [DIGITS];

   logic [3:0]        w_an_low;
   logic              w_active;
   logic [1:0]        w_idx;
   logic [11:0]       w_sample;
   logic              w_same;
   logic [STAB_W-1:0] w_stab_next;
   logic              w_capture;
   logic [NIB_W-1:0]  w_nib;
   logic              w_pat_err;
   logic              w_frame_done;
   logic              w_to_fire;
   logic [3:0]        w_seen_next;
   logic [15:0]       w_frame_value;
   logic [3:0]        w_frame_dp;
   logic              w_frame_err;

   seg7_decode u_decode (
      .i_seg    (r_seg_s2[PAT_W-1:0]),
      .o_nibble (w_nib),
      .o_err    (w_pat_err)
   );

   // Two-flop synchronizers for the asynchronous display lines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_an_s1  <= '0;
         r_an_s2  <= '0;
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
      end else begin
         r_an_s1  <= an_in;
         r_an_s2  <= r_an_s1;
         r_seg_s1 <= seg_in;
         r_seg_s2 <= r_seg_s1;
      end
   end

   // Active digit detection, stability tracking and capture decision.
   always_comb begin
      w_an_low = ~r_an_s2;
      w_active = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
      w_idx    = 2'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_an_low[i]) w_idx = 2'(i);
      end
      w_sample = {r_an_s2, r_seg_s2};
      w_same   = (w_sample == r_prev) && (r_stab != '0);
      if (!w_active)             w_stab_next = '0;
      else if (!w_same)          w_stab_next = STAB_W'(1);
      else if (r_stab == STAB_MAX) w_stab_next = r_stab;
      else                       w_stab_next = r_stab + STAB_W'(1);
      // Saturated dwell means this sample was already captured.
      w_capture = w_active && (w_stab_next == STAB_MAX) &&
                  !(w_same && (r_stab == STAB_MAX));
   end

   // Frame completion, timeout and next seen mask; a capture beats the timeout.
   always_comb begin
      w_frame_done = (r_seen == 4'hF);
      w_to_fire    = (r_seen != 4'd0) && !w_frame_done && (r_to >= TO_LAST) && !w_capture;
      w_seen_next  = (w_frame_done || w_to_fire) ? 4'd0 : r_seen;
      if (w_capture) w_seen_next[w_idx] = 1'b1;
      w_frame_value = '0;
      w_frame_dp    = '0;
      w_frame_err   = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         w_frame_value[4*k +: 4] = r_slot[k].nib;
         w_frame_dp[k]           = r_slot[k].dp;
         w_frame_err             = w_frame_err | r_slot[k].err;
      end
   end

   // Stability counter, slot storage, seen mask and inter-capture timer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev <= '0;
         r_stab <= '0;
         r_to   <= '0;
         r_seen <= '0;
         for (int k = 0; k < DIGITS; k++) r_slot[k] <= '0;
      end else begin
         r_prev <= w_sample;
         r_stab <= w_stab_next;
         r_seen <= w_seen_next;
         if (w_frame_done || w_to_fire) begin
            for (int k = 0; k < DIGITS; k++) r_slot[k].err <= 1'b0;
         end
         if (w_capture) r_slot[w_idx] <= '{nib: w_nib, dp: ~r_seg_s2[7], err: w_pat_err};
         if (w_capture || w_frame_done || w_to_fire || (r_seen == 4'd0)) r_to <= '0;
         else if (r_to != TO_MAX)                                         r_to <= r_to + TO_W'(1);
      end
   end

   // Output registers: frame load on completion, single-cycle status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value       <= '0;
         dp_out      <= '0;
         frame_err   <= 1'b0;
         value_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         value_valid <= w_frame_done;
         timeout     <= w_to_fire;
         if (w_frame_done) begin
            value     <= w_frame_value;
            dp_out    <= w_frame_dp;
            frame_err <= w_frame_err;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture with a frame scoreboard.
module tb_seg_display_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  an_in = 4'hF;
   logic [7:0]  seg_in = 8'hFF;
   logic [15:0] value;
   logic [3:0]  dp_out;
   logic        value_valid;
   logic        frame_err;
   logic        timeout;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  dp;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_valid = 0;
   int   n_to = 0;

   seg_display_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
      .clk         (clk),
      .reset       (reset),
      .an_in       (an_in),
      .seg_in      (seg_in),
      .value       (value),
      .dp_out      (dp_out),
      .value_valid (value_valid),
      .frame_err   (frame_err),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int idx, input logic [6:0] pat, input logic dp_lit, input int n);
      an_in  = ~(4'b0001 << idx);
      seg_in = {~dp_lit, pat};
      tick(n);
   endtask

   task automatic blank(input int n);
      an_in  = 4'hF;
      seg_in = 8'hFF;
      tick(n);
   endtask

   // Scoreboard: every value_valid must match the oldest expected frame.
   always @(negedge clk) begin
      if (reset === 1'b1 && timeout === 1'b1) n_to++;
      if (reset === 1'b1 && value_valid === 1'b1) begin
         n_valid++;
         checks++;
         assert (q.size() > 0) else begin
            failures++;
            $error("FAIL frame_unexpected observed=%0h expected=none", value);
         end
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            assert (value === e.v) else begin
               failures++;
               $error("FAIL frame_value observed=%0h expected=%0h", value, e.v);
            end
            checks++;
            assert (dp_out === e.dp) else begin
               failures++;
               $error("FAIL frame_dp observed=%0h expected=%0h", dp_out, e.dp);
            end
            checks++;
            assert (frame_err === e.err) else begin
               failures++;
               $error("FAIL frame_err observed=%0h expected=%0h", frame_err, e.err);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int first_to;
      int to_before;
      int valid_before;

      // Reset state
      tick(3);
      @(negedge clk);
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_dp", 32'(dp_out), 32'h0);
      chk("rst_valid", 32'(value_valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      tick(2);

      // Scan 4,0,9,5 twice; measure latency of the completing digit
      q.push_back('{v: 16'h5904, dp: 4'h0, err: 1'b0});
      drive(0, 7'h19, 1'b0, 8);
      drive(1, 7'h40, 1'b0, 8);
      drive(2, 7'h10, 1'b0, 8);
      an_in  = 4'b0111;
      seg_in = 8'h92;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         tick(1);
         if (value_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      chk("latency", 32'(lat), 32'd7);
      tick(1);
      q.push_back('{v: 16'h5904, dp: 4'h0, err: 1'b0});
      drive(0, 7'h19, 1'b0, 8);
      drive(1, 7'h40, 1'b0, 8);
      drive(2, 7'h10, 1'b0, 8);
      drive(3, 7'h12, 1'b0, 8);
      blank(10);
      chk("scan_valid_count", 32'(n_valid), 32'd2);

      // Digit 2 blank pattern flags a frame error
      q.push_back('{v: 16'h3021, dp: 4'h0, err: 1'b1});
      drive(0, 7'h79, 1'b0, 8);
      drive(1, 7'h24, 1'b0, 8);
      drive(2, 7'h7F, 1'b0, 8);
      drive(3, 7'h30, 1'b0, 8);
      blank(10);
      chk("err_valid_count", 32'(n_valid), 32'd3);

      // Dwell of only 3 cycles never captures
      for (int r = 0; r < 3; r++) begin
         drive(0, 7'h40, 1'b0, 3);
         drive(1, 7'h79, 1'b0, 3);
         drive(2, 7'h24, 1'b0, 3);
         drive(3, 7'h30, 1'b0, 3);
      end
      blank(20);
      chk("short_dwell_valid", 32'(n_valid), 32'd3);
      chk("short_dwell_timeout", 32'(n_to), 32'd0);

      // Partial frame then blanking: one timeout, value untouched
      drive(0, 7'h79, 1'b0, 8);
      drive(1, 7'h24, 1'b0, 8);
      an_in  = 4'hF;
      seg_in = 8'hFF;
      first_to = 0;
      for (int n = 1; n <= 300; n++) begin
         tick(1);
         if (timeout === 1'b1 && first_to == 0) first_to = n;
      end
      chk("timeout_time", 32'(first_to), 32'd98);
      chk("timeout_count", 32'(n_to), 32'd1);
      chk("timeout_value", 32'(value), 32'h3021);
      chk("timeout_valid", 32'(n_valid), 32'd3);

      // Two enables low: blanking, no capture, so no timeout either
      to_before = n_to;
      valid_before = n_valid;
      an_in  = 4'b1100;
      seg_in = 8'hC0;
      tick(20);
      blank(150);
      chk("multi_low_timeout", 32'(n_to), 32'(to_before));
      chk("multi_low_valid", 32'(n_valid), 32'(valid_before));

      // Decimal point lit on digit 3 only
      q.push_back('{v: 16'hFA87, dp: 4'b1000, err: 1'b0});
      drive(0, 7'h78, 1'b0, 8);
      drive(1, 7'h00, 1'b0, 8);
      drive(2, 7'h08, 1'b0, 8);
      drive(3, 7'h0E, 1'b1, 8);
      blank(10);
      chk("dp_valid_count", 32'(n_valid), 32'd4);
      chk("dp_out_held", 32'(dp_out), 32'h8);

      // Reset mid-frame discards three captured digits
      drive(0, 7'h79, 1'b0, 8);
      drive(1, 7'h24, 1'b0, 8);
      drive(2, 7'h30, 1'b0, 8);
      an_in  = 4'hF;
      seg_in = 8'hFF;
      reset  = 1'b0;
      #2;
      chk("midrst_value", 32'(value), 32'h0);
      chk("midrst_dp", 32'(dp_out), 32'h0);
      chk("midrst_ferr", 32'(frame_err), 32'h0);
      chk("midrst_valid", 32'(value_valid), 32'h0);
      chk("midrst_timeout", 32'(timeout), 32'h0);
      tick(3);
      reset = 1'b1;
      tick(2);
      q.push_back('{v: 16'h654C, dp: 4'h0, err: 1'b0});
      drive(3, 7'h02, 1'b0, 8);
      drive(2, 7'h12, 1'b0, 8);
      drive(1, 7'h19, 1'b0, 8);
      drive(0, 7'h46, 1'b0, 8);
      blank(10);
      chk("post_rst_valid", 32'(n_valid), 32'd5);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
